// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared 128 x 16 main RAM: serialises word reads and
// writes from the CPU (port 0) and the loader/DMA (port 1) onto the RAM pins.
module mem_arbiter #(
  parameter int RD_LAT     = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [6:0]  addr0,
  input  logic [6:0]  addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic [6:0]  mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);
  localparam bit         RR       = (FIXED_PRIO == 0);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        port_q, port_d;
  logic        last_q, last_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;
  logic [6:0]  mem_addr_q, mem_addr_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;
  logic        win;

  // Port 1 wins when alone, or on a tie under round-robin if port 0 went last.
  assign win = req1 & (~req0 | (RR & ~last_q));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    port_d      = port_q;
    last_d      = last_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          port_d     = win;
          last_d     = win;
          gnt_d      = win ? 2'b10 : 2'b01;
          mem_addr_d = win ? addr1 : addr0;
          if (win ? we1 : we0) begin
            mem_wr_d    = 1'b1;
            mem_wdata_d = win ? wdata1 : wdata0;
            state_d     = WRITE;
          end else begin
            mem_rd_d = 1'b1;
            cnt_d    = CNT_INIT;
            state_d  = READ;
          end
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        if (cnt_q == 3'd0) begin
          mem_rd_d = 1'b0;
          rvalid_d = port_q ? 2'b10 : 2'b01;
          if (port_q) rdata1_d = mem_rdata;
          else        rdata0_d = mem_rdata;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        mem_rd_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      port_q      <= 1'b0;
      last_q      <= 1'b1;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      port_q      <= port_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt0      = gnt_q[0];
  assign gnt1      = gnt_q[1];
  assign rvalid0   = rvalid_q[0];
  assign rvalid1   = rvalid_q[1];
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance on a registered RAM model,
// plus a fixed-priority instance sharing the same request stimulus.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [6:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;

  logic        gnt0, gnt1, rvalid0, rvalid1, mem_rd, mem_wr, busy;
  logic [15:0] rdata0, rdata1, mem_wdata;
  logic [15:0] mem_rdata;
  logic [6:0]  mem_addr;

  logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mem_rd, b_mem_wr, b_busy;
  logic [15:0] b_rdata0, b_rdata1, b_mem_wdata;
  logic [6:0]  b_mem_addr;

  logic [15:0] ram [0:127];
  logic        pre_wr;
  logic [6:0]  pre_addr;
  logic [15:0] pre_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.RD_LAT(2), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.RD_LAT(2), .FIXED_PRIO(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
    .rdata0(b_rdata0), .rdata1(b_rdata1),
    .mem_addr(b_mem_addr), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
    .mem_wdata(b_mem_wdata), .mem_rdata(16'h0000), .busy(b_busy)
  );

  // RAM with one registered read stage; idle reads return a poison value so an
  // early capture shows up as a wrong rdata.
  always @(posedge clk) begin
    if (pre_wr)      ram[pre_addr] <= pre_data;
    else if (mem_wr) ram[mem_addr] <= mem_wdata;
    mem_rdata <= mem_rd ? ram[mem_addr] : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a read on port p, checking grant, strobe length and return timing.
  task automatic do_read(input bit p, input logic [6:0] a, input logic [15:0] exp);
    if (p) begin req1 = 1'b1; we1 = 1'b0; addr1 = a; end
    else   begin req0 = 1'b1; we0 = 1'b0; addr0 = a; end
    step();
    check("rd_gnt", {gnt1, gnt0}, p ? 2'b10 : 2'b01);
    check("rd_pins", {mem_rd, mem_wr, busy, mem_addr}, {3'b101, a});
    req0 = 1'b0; req1 = 1'b0;
    step();
    check("rd_hold", {gnt1, gnt0, mem_rd, busy, rvalid1, rvalid0}, 6'b001100);
    step();
    check("rd_done", {mem_rd, busy, rvalid1, rvalid0}, p ? 4'b0010 : 4'b0001);
    check("rd_data", p ? rdata1 : rdata0, exp);
    step();
    check("rd_pulse", {rvalid1, rvalid0}, 2'b00);
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 7'h05; addr1 = 7'h10; wdata0 = '0; wdata1 = '0;
    pre_wr = 1'b1; pre_addr = 7'h05; pre_data = 16'h8001;
    step();
    pre_addr = 7'h22; pre_data = 16'h0000;
    step();
    pre_addr = 7'h10; pre_data = 16'h0777;
    step();
    pre_wr = 1'b0;

    // Reset held three edges with both requests high
    check("rst_strobes", {gnt1, gnt0, rvalid1, rvalid0, mem_rd, mem_wr, busy}, 7'b0);
    check("rst_addr", mem_addr, 7'h00);
    check("rst_wdata", mem_wdata, 16'h0000);
    check("rst_rdata", {rdata1, rdata0}, 32'h0);

    // First tie after reset goes to port 0, both instances
    rst_n = 1'b1;
    step();
    check("tie_gnt", {gnt1, gnt0}, 2'b01);
    check("tie_gnt_fp", {b_gnt1, b_gnt0}, 2'b01);
    check("tie_rd", {mem_rd, mem_addr}, {1'b1, 7'h05});
    req0 = 1'b0; req1 = 1'b0;
    step(); step(); step();

    // Single read of a negative word
    do_read(1'b0, 7'h05, 16'h8001);

    // Port 1 write then read back
    req1 = 1'b1; we1 = 1'b1; addr1 = 7'h7F; wdata1 = 16'h1234;
    step();
    check("wr_gnt", {gnt1, gnt0}, 2'b10);
    check("wr_pins", {mem_wr, mem_rd, busy, mem_addr}, {3'b101, 7'h7F});
    check("wr_data", mem_wdata, 16'h1234);
    req1 = 1'b0; we1 = 1'b0;
    step();
    check("wr_single", {mem_wr, busy}, 2'b00);
    do_read(1'b1, 7'h7F, 16'h1234);
    check("wr_p0_quiet", rvalid0, 1'b0);

    // Contention: both hold reads; RR alternates (port 1 went last), fixed prio starves port 1
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 7'h05; addr1 = 7'h7F;
    for (int i = 1; i <= 18; i++) begin
      step();
      check("rr_gnt", {gnt1, gnt0},
            (i % 3 == 1) ? ((((i - 1) / 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00);
      check("fp_gnt", {b_gnt1, b_gnt0}, (i % 3 == 1) ? 2'b01 : 2'b00);
    end
    check("rr_last_data", rdata1, 16'h1234);
    req0 = 1'b0; req1 = 1'b0;
    step();
    check("rr_idle", {gnt1, gnt0, busy}, 3'b000);

    // Withdrawal: port 1 write request raised during port 0 read, dropped before IDLE
    req0 = 1'b1; addr0 = 7'h05;
    step();
    check("wd_gnt0", gnt0, 1'b1);
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 7'h22; wdata1 = 16'hBEEF;
    step();
    check("wd_nogrant1", gnt1, 1'b0);
    req1 = 1'b0; we1 = 1'b0;
    step();
    check("wd_rvalid0", {rvalid0, rdata0}, {1'b1, 16'h8001});
    step();
    check("wd_quiet", {gnt1, gnt0, mem_rd, mem_wr, busy}, 5'b0);
    step();
    check("wd_ram", ram[7'h22], 16'h0000);

    // Reset one cycle after a read grant aborts it
    req0 = 1'b1; addr0 = 7'h05;
    step();
    check("mr_gnt", {gnt0, mem_rd}, 2'b11);
    req0 = 1'b0;
    rst_n = 1'b0;
    step();
    check("mr_abort", {mem_rd, busy, rvalid0}, 3'b000);
    check("mr_rdata", rdata0, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mr_no_rvalid", {rvalid0, mem_rd, rdata0}, 18'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
